program_sequencer: RTL and testbench



---
 rtl/program_sequencer.sv | 160 ++++++++++++++++
 tb/tb_program_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: two-pass program sequencer for the 8-bit single-cycle core.
// The label pass records every stl address into a label table. The execute pass then
// walks the program and resolves blt targets from that table.
// Optional feature: define SEQ_CYCLE_COUNT_EN to build the saturating EXEC-cycle counter.
// When it is undefined, cycleCount is tied to zero.
module program_sequencer #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned LBL_N = 16
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            start,
    input  logic [7:0]      instruction,
    input  logic            stall,
    input  logic            branchTaken,
    output logic [PC_W-1:0] pc,
    output logic            labelPassFlag,
    output logic            execValid,
    output logic            haltFlag,
    output logic            errorFlag,
    output logic [15:0]     cycleCount
);

    localparam int unsigned LBL_W = $clog2(LBL_N);
    localparam logic [3:0] OpStl = 4'b0111;
    localparam logic [3:0] OpBlt = 4'b1001;
    localparam logic [3:0] OpHlt = 4'b1110;

    typedef enum logic [1:0] {StIdle, StLabel, StExec, StHalted} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              err_q, err_d;
    logic [LBL_N-1:0]  valid_q, valid_d;
    logic [PC_W-1:0]   lbl_table_q [LBL_N];

    logic [3:0]        opcode;
    logic [LBL_W-1:0]  lbl_idx;
    logic              pc_last;
    logic              run_start;
    logic              lbl_we;

    assign opcode    = instruction[7:4];
    assign lbl_idx   = instruction[LBL_W-1:0];
    assign pc_last   = (pc_q == {PC_W{1'b1}});
    // start is honoured only when no pass is running; stall does not gate it
    assign run_start = start && ((state_q == StIdle) || (state_q == StHalted));
    assign lbl_we    = (state_q == StLabel) && !stall && (opcode == OpStl);

    // Next-state, PC and fault logic for the two passes
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                pc_d = '0;
                if (run_start) begin
                    state_d = StLabel;
                    valid_d = '0;
                    err_d   = 1'b0;
                end
            end
            StLabel: begin
                if (!stall) begin
                    if (opcode == OpStl) begin
                        valid_d[lbl_idx] = 1'b1;
                    end
                    if (opcode == OpHlt) begin
                        pc_d    = '0;
                        state_d = StExec;
                    end else if (pc_last) begin
                        // Ran off the end of program space without a hlt
                        err_d   = 1'b1;
                        state_d = StHalted;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            StExec: begin
                if (!stall) begin
                    if ((opcode == OpBlt) && branchTaken) begin
                        if (valid_q[lbl_idx]) begin
                            pc_d = lbl_table_q[lbl_idx];
                        end else begin
                            err_d   = 1'b1;
                            state_d = StHalted;
                        end
                    end else if (opcode == OpHlt) begin
                        state_d = StHalted;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            StHalted: begin
                if (run_start) begin
                    state_d = StLabel;
                    pc_d    = '0;
                    valid_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                pc_d    = '0;
            end
        endcase
    end

    // State, PC, sticky error and label-valid registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            pc_q    <= '0;
            err_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    // Label table data; only the valid bits need a reset
    always_ff @(posedge clk) begin
        if (lbl_we) begin
            lbl_table_q[lbl_idx] <= pc_q;
        end
    end

    assign pc            = pc_q;
    assign errorFlag     = err_q;
    assign labelPassFlag = (state_q == StLabel);
    assign execValid     = (state_q == StExec) && !stall;
    assign haltFlag      = (state_q == StHalted);

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cnt_q;

    // Saturating count of executed cycles, cleared on each accepted start
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else if (run_start) begin
            cnt_q <= '0;
        end else if (execValid && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cycleCount = cnt_q;
`else
    assign cycleCount = '0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: scenario tasks checked against a program-level reference
// model (mode + PC + label dictionary).
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic [7:0]  instruction;
    logic        stall;
    logic        branchTaken;
    logic [7:0]  pc;
    logic        labelPassFlag;
    logic        execValid;
    logic        haltFlag;
    logic        errorFlag;
    logic [15:0] cycleCount;

    logic [7:0]  mem [256];

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 label pass, 2 execute pass, 3 halted
    int   m_mode;
    int   m_pc;
    int   m_cnt;
    logic m_err;
    int   m_lbl [16];

    always #5 clk = ~clk;

    assign instruction = mem[pc];

    program_sequencer #(.PC_W(8), .LBL_N(16)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .start        (start),
        .instruction  (instruction),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .pc           (pc),
        .labelPassFlag(labelPassFlag),
        .execValid    (execValid),
        .haltFlag     (haltFlag),
        .errorFlag    (errorFlag),
        .cycleCount   (cycleCount)
    );

    logic [27:0] obs_vec;
    assign obs_vec = {pc, labelPassFlag, execValid, haltFlag, errorFlag, cycleCount};

    function automatic logic [27:0] exp_vec();
        logic [15:0] c;
        logic [7:0]  p;
`ifdef SEQ_CYCLE_COUNT_EN
        c = m_cnt[15:0];
`else
        c = 16'd0;
`endif
        p = m_pc[7:0];
        return {p, m_mode == 1, (m_mode == 2) && !stall, m_mode == 3, m_err, c};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
        for (int i = 0; i < 16; i++) m_lbl[i] = -1;
    endtask

    // Advance the model by one clock using the inputs currently applied, then clock the DUT
    task automatic step();
        int   n_mode = m_mode;
        int   n_pc   = m_pc;
        int   n_cnt  = m_cnt;
        logic n_err  = m_err;
        int   op     = int'(mem[m_pc][7:4]);
        int   v      = int'(mem[m_pc][3:0]);
        if ((m_mode == 0 || m_mode == 3) && start) begin
            n_mode = 1;
            n_pc   = 0;
            n_cnt  = 0;
            n_err  = 1'b0;
            for (int i = 0; i < 16; i++) m_lbl[i] = -1;
        end else if (m_mode == 1 && !stall) begin
            if (op == 14) begin
                n_mode = 2;
                n_pc   = 0;
            end else begin
                if (op == 7) m_lbl[v] = m_pc;
                if (m_pc == 255) begin
                    n_err  = 1'b1;
                    n_mode = 3;
                end else begin
                    n_pc = m_pc + 1;
                end
            end
        end else if (m_mode == 2 && !stall) begin
            if (m_cnt < 65535) n_cnt = m_cnt + 1;
            if (op == 9 && branchTaken) begin
                if (m_lbl[v] >= 0) begin
                    n_pc = m_lbl[v];
                end else begin
                    n_err  = 1'b1;
                    n_mode = 3;
                end
            end else if (op == 14) begin
                n_mode = 3;
            end else begin
                n_pc = (m_pc + 1) % 256;
            end
        end
        @(posedge clk);
        #1;
        m_mode = n_mode;
        m_pc   = n_pc;
        m_cnt  = n_cnt;
        m_err  = n_err;
    endtask

    task automatic fill(input logic [7:0] w);
        for (int a = 0; a < 256; a++) mem[a] = w;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++;
        if (obs_vec !== 28'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", obs_vec, 28'd0);
        end
        resetN = 1'b1;
        step();
        #2;
        total++;
        if (obs_vec !== exp_vec()) begin
            bad++;
            $display("FAIL reset_idle got=%h want=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [15:0] want_cnt;
        fill(8'h21);
        mem[0] = 8'h73; mem[1] = 8'h21; mem[2] = 8'hE0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && m_mode != 3; c++) begin
            #2;
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL basic cyc=%0d got=%h want=%h", c, obs_vec, exp_vec());
            end
            step();
        end
        #2;
        total++;
        if ({haltFlag, errorFlag, pc} !== {1'b1, 1'b0, 8'd2}) begin
            bad++;
            $display("FAIL basic_halt got=%b%b pc=%0d want=10 pc=2", haltFlag, errorFlag, pc);
        end
`ifdef SEQ_CYCLE_COUNT_EN
        want_cnt = 16'd3;
`else
        want_cnt = 16'd0;
`endif
        total++;
        if (cycleCount !== want_cnt) begin
            bad++;
            $display("FAIL basic_count got=%0d want=%0d", cycleCount, want_cnt);
        end
    endtask

    task automatic test_branch();
        int loops = 0;
        fill(8'h21);
        mem[0] = 8'h75; mem[1] = 8'h21; mem[2] = 8'h95; mem[3] = 8'hE0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 60 && m_mode != 3; c++) begin
            branchTaken = (loops < 2);
            #2;
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL branch cyc=%0d got=%h want=%h", c, obs_vec, exp_vec());
            end
            if (m_mode == 2 && m_pc == 2 && branchTaken) begin
                loops++;
                step();
                total++;
                if ({pc, execValid} !== {8'd0, 1'b1}) begin
                    bad++;
                    $display("FAIL branch_target got=%0d/%b want=0/1", pc, execValid);
                end
            end else begin
                step();
            end
        end
        branchTaken = 1'b0;
        #2;
        total++;
        if ({haltFlag, errorFlag, pc} !== {1'b1, 1'b0, 8'd3}) begin
            bad++;
            $display("FAIL branch_fallthru got=%b%b pc=%0d want=10 pc=3", haltFlag, errorFlag, pc);
        end
    endtask

    task automatic test_unset_label();
        fill(8'h21);
        mem[0] = 8'h21; mem[1] = 8'h9A; mem[2] = 8'hE0;
        branchTaken = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && m_mode != 3; c++) begin
            #2;
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL unset cyc=%0d got=%h want=%h", c, obs_vec, exp_vec());
            end
            step();
        end
        branchTaken = 1'b0;
        step();
        #2;
        total++;
        if ({haltFlag, errorFlag, pc} !== {1'b1, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL unset_err got=%b%b pc=%0d want=11 pc=1", haltFlag, errorFlag, pc);
        end
    endtask

    task automatic test_no_hlt();
        fill(8'h21);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 300 && m_mode != 3; c++) begin
            #2;
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL nohlt cyc=%0d got=%h want=%h", c, obs_vec, exp_vec());
            end
            step();
        end
        #2;
        total++;
        if ({haltFlag, errorFlag, pc, cycleCount} !== {1'b1, 1'b1, 8'd255, 16'd0}) begin
            bad++;
            $display("FAIL nohlt_end got=%b%b pc=%0d cnt=%0d want=11 pc=255 cnt=0",
                     haltFlag, errorFlag, pc, cycleCount);
        end
    endtask

    task automatic test_stall();
        fill(8'h21);
        mem[0] = 8'h73; mem[1] = 8'h21; mem[2] = 8'hE0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && !(m_mode == 2 && m_pc == 1); c++) step();
        stall = 1'b1;
        branchTaken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            total++;
            if ({pc, execValid, labelPassFlag, haltFlag} !== {8'd1, 3'b000}) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got pc=%0d ev=%b want pc=1 ev=0", c, pc, execValid);
            end
            step();
        end
        stall = 1'b0;
        branchTaken = 1'b0;
        #2;
        total++;
        if ({pc, execValid} !== {8'd1, 1'b1}) begin
            bad++;
            $display("FAIL stall_resume got pc=%0d ev=%b want pc=1 ev=1", pc, execValid);
        end
        step();
        #2;
        total++;
        if ({pc, execValid} !== {8'd2, 1'b1}) begin
            bad++;
            $display("FAIL stall_next got pc=%0d ev=%b want pc=2 ev=1", pc, execValid);
        end
        step();
    endtask

    task automatic test_reset_mid();
        fill(8'h21);
        mem[0] = 8'h75; mem[1] = 8'h21; mem[2] = 8'hE0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && !(m_mode == 2 && m_pc == 1); c++) step();
        #2;
        resetN = 1'b0;
        #1;
        total++;
        if (obs_vec !== 28'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=%h", obs_vec, 28'd0);
        end
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        fill(8'h21);
        mem[0] = 8'h21; mem[1] = 8'h95; mem[2] = 8'hE0;
        branchTaken = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && m_mode != 3; c++) begin
            #2;
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("FAIL rerun cyc=%0d got=%h want=%h", c, obs_vec, exp_vec());
            end
            step();
        end
        branchTaken = 1'b0;
        #2;
        total++;
        if ({haltFlag, errorFlag, pc} !== {1'b1, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL rerun_err got=%b%b pc=%0d want=11 pc=1", haltFlag, errorFlag, pc);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < 256; a++) begin
                int r = $urandom_range(0, 9);
                if (r < 3) mem[a] = {4'h7, 4'($urandom_range(0, 7))};
                else if (r < 5) mem[a] = {4'h9, 4'($urandom_range(0, 8))};
                else mem[a] = 8'($urandom_range(0, 255));
            end
            mem[$urandom_range(4, 40)] = 8'hE0;
            start = 1'b1;
            step();
            for (int c = 0; c < 300; c++) begin
                start       = ($urandom_range(0, 31) == 0);
                stall       = ($urandom_range(0, 3) == 0);
                branchTaken = $urandom_range(0, 1) == 1;
                #2;
                total++;
                if (obs_vec !== exp_vec()) begin
                    bad++;
                    $display("FAIL random prog=%0d cyc=%0d got=%h want=%h",
                             p, c, obs_vec, exp_vec());
                end
                step();
            end
            start = 1'b0;
            stall = 1'b0;
            branchTaken = 1'b0;
        end
    endtask

    initial begin
        start       = 1'b0;
        stall       = 1'b0;
        branchTaken = 1'b0;
        fill(8'h21);
        model_reset();
        test_reset();
        test_basic();
        test_branch();
        test_unset_label();
        test_no_hlt();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
